// File: rtl/preflop_eval_scheduler.sv
// Walks the four seats of a hand round, drives each requested seat's hole cards
// to a shared starting-hand evaluator and turns the strength into fold/call/raise.
module preflop_eval_scheduler (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  seat_req,
  input  logic [47:0] seat_cards,
  input  logic [2:0]  call_thr,
  input  logic [2:0]  raise_thr,
  output logic [5:0]  eval_card1,
  output logic [5:0]  eval_card2,
  input  logic [2:0]  eval_strength,
  output logic        eval_req,
  output logic        busy,
  output logic        done,
  output logic [11:0] strength_all,
  output logic [7:0]  action_all,
  output logic [3:0]  card_err
);

  typedef enum logic [2:0] {IDLE, SEL, EVAL, CAP, DONE} state_t;

  localparam logic [1:0] ACT_FOLD  = 2'b00;
  localparam logic [1:0] ACT_CALL  = 2'b01;
  localparam logic [1:0] ACT_RAISE = 2'b10;
  localparam logic [1:0] ACT_OUT   = 2'b11;

  state_t      state, state_next;
  logic [1:0]  ptr;
  logic [3:0]  req_q;
  logic [47:0] cards_q;
  logic [2:0]  call_q, raise_q;
  logic        cards_ok;
  logic [2:0]  seat_strength;

  function automatic logic rank_ok(input logic [5:0] card);
    return (card[3:0] >= 4'd2) && (card[3:0] <= 4'd14);
  endfunction

  // Cards under evaluation stay in eval_card1/2 through CAP, so validity is
  // derived from them rather than from a separate copy.
  assign cards_ok      = rank_ok(eval_card1) && rank_ok(eval_card2) && (eval_card1 != eval_card2);
  assign seat_strength = strength_all[3*int'(ptr) +: 3];

  assign busy     = (state == SEL) || (state == EVAL) || (state == CAP);
  assign done     = (state == DONE);
  assign eval_req = (state == EVAL);

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start && (seat_req != 4'd0)) state_next = SEL;
      SEL: begin
        if (req_q[ptr])        state_next = EVAL;
        else if (ptr == 2'd3)  state_next = DONE;
        else                   state_next = SEL;
      end
      EVAL:    state_next = CAP;
      CAP:     state_next = (ptr == 2'd3) ? DONE : SEL;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ptr          <= 2'd0;
      req_q        <= 4'd0;
      cards_q      <= 48'd0;
      call_q       <= 3'd0;
      raise_q      <= 3'd0;
      eval_card1   <= 6'd0;
      eval_card2   <= 6'd0;
      strength_all <= 12'd0;
      action_all   <= 8'd0;
      card_err     <= 4'd0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start && (seat_req != 4'd0)) begin
            req_q        <= seat_req;
            cards_q      <= seat_cards;
            call_q       <= call_thr;
            raise_q      <= raise_thr;
            strength_all <= 12'd0;
            action_all   <= 8'd0;
            card_err     <= 4'd0;
            ptr          <= 2'd0;
          end
        end
        SEL: begin
          if (req_q[ptr]) begin
            eval_card1 <= cards_q[12*int'(ptr)+6 +: 6];
            eval_card2 <= cards_q[12*int'(ptr)   +: 6];
          end else begin
            action_all[2*int'(ptr) +: 2]   <= ACT_OUT;
            strength_all[3*int'(ptr) +: 3] <= 3'd0;
            if (ptr != 2'd3) ptr <= ptr + 2'd1;
          end
        end
        EVAL: begin
          strength_all[3*int'(ptr) +: 3] <= cards_ok ? eval_strength : 3'd0;
          card_err[ptr]                  <= !cards_ok;
        end
        CAP: begin
          // Invalid cards fold even when a zero call threshold would call.
          if (!cards_ok)                     action_all[2*int'(ptr) +: 2] <= ACT_FOLD;
          else if (seat_strength >= raise_q) action_all[2*int'(ptr) +: 2] <= ACT_RAISE;
          else if (seat_strength >= call_q)  action_all[2*int'(ptr) +: 2] <= ACT_CALL;
          else                               action_all[2*int'(ptr) +: 2] <= ACT_FOLD;
          if (ptr != 2'd3) ptr <= ptr + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_preflop_eval_scheduler.sv
// Randomized bench for preflop_eval_scheduler: a table-driven evaluator stand-in
// and a per-seat reference model of the expected round results and timing.
module tb_preflop_eval_scheduler;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [3:0]  seat_req;
  logic [47:0] seat_cards;
  logic [2:0]  call_thr, raise_thr, eval_strength;
  logic [5:0]  eval_card1, eval_card2;
  logic        eval_req, busy, done;
  logic [11:0] strength_all;
  logic [7:0]  action_all;
  logic [3:0]  card_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [2:0]  eval_tbl [4096];
  logic [11:0] exp_s;
  logic [7:0]  exp_a;
  logic [3:0]  exp_e;

  preflop_eval_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .seat_req(seat_req), .seat_cards(seat_cards),
    .call_thr(call_thr), .raise_thr(raise_thr), .eval_card1(eval_card1),
    .eval_card2(eval_card2), .eval_strength(eval_strength), .eval_req(eval_req),
    .busy(busy), .done(done), .strength_all(strength_all), .action_all(action_all),
    .card_err(card_err)
  );

  always #5 clk = ~clk;

  assign eval_strength = eval_tbl[{eval_card1, eval_card2}];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] mk(input logic [1:0] suit, input logic [3:0] rank);
    return {suit, rank};
  endfunction

  function automatic logic [11:0] rand_hand();
    logic [3:0] r1, r2;
    logic [1:0] s1, s2;
    r1 = 4'(2 + $urandom_range(0, 12));
    r2 = 4'(2 + $urandom_range(0, 12));
    s1 = 2'($urandom);
    s2 = 2'($urandom);
    case ($urandom_range(0, 9))
      0: r1 = ($urandom_range(0, 2) == 2) ? 4'd15 : 4'($urandom_range(0, 1));
      1: r2 = ($urandom_range(0, 2) == 2) ? 4'd15 : 4'($urandom_range(0, 1));
      2: begin s2 = s1; r2 = r1; end
      default: ;
    endcase
    return {s1, r1, s2, r2};
  endfunction

  // Expected per-seat outcome straight from the round rules.
  task automatic model(input logic [3:0] req, input logic [47:0] cards, input logic [2:0] ct,
                       input logic [2:0] rt, output logic [11:0] s, output logic [7:0] a,
                       output logic [3:0] e);
    s = '0; a = '0; e = '0;
    for (int i = 0; i < 4; i++) begin
      logic [5:0] c1, c2;
      logic [2:0] v;
      logic       valid;
      c1 = cards[12*i+6 +: 6];
      c2 = cards[12*i +: 6];
      valid = (c1[3:0] >= 2) && (c1[3:0] <= 14) && (c2[3:0] >= 2) && (c2[3:0] <= 14) && (c1 != c2);
      if (!req[i]) begin
        a[2*i +: 2] = 2'b11;
      end else if (!valid) begin
        e[i] = 1'b1;
      end else begin
        v = eval_tbl[{c1, c2}];
        s[3*i +: 3] = v;
        a[2*i +: 2] = (v >= rt) ? 2'b10 : (v >= ct) ? 2'b01 : 2'b00;
      end
    end
  endtask

  task automatic run_round(input string tag, input logic [3:0] req, input logic [47:0] cards,
                           input logic [2:0] ct, input logic [2:0] rt, input bit poke);
    int n, k, pulses;
    model(req, cards, ct, rt, exp_s, exp_a, exp_e);
    n = $countones(req);
    @(negedge clk);
    start = 1'b1; seat_req = req; seat_cards = cards; call_thr = ct; raise_thr = rt;
    @(posedge clk); #1;
    start = 1'b0;
    seat_req = 4'($urandom); seat_cards = {16'($urandom), 32'($urandom)};
    call_thr = 3'($urandom); raise_thr = 3'($urandom);
    check({tag, "_busy"}, busy, 1);
    k = 1; pulses = 0;
    while (!done && k < 60) begin
      if (eval_req) pulses++;
      if (poke && k == 3) begin start = 1'b1; seat_req = 4'hF; end
      if (poke && k == 4) start = 1'b0;
      @(posedge clk); #1;
      k++;
    end
    check({tag, "_latency"}, k, 1 + 3*n + (4 - n));
    check({tag, "_pulses"}, pulses, n);
    check({tag, "_strength"}, strength_all, exp_s);
    check({tag, "_action"}, action_all, exp_a);
    check({tag, "_err"}, card_err, exp_e);
    @(posedge clk); #1;
    check({tag, "_done_once"}, {busy, done}, 2'b00);
    check({tag, "_hold"}, {strength_all, action_all, card_err}, {exp_s, exp_a, exp_e});
  endtask

  logic [5:0]  c_a, c_b;
  logic [11:0] h0, h1, h2, h3;
  logic [47:0] round4;

  initial begin
    int cnt;
    for (int i = 0; i < 4096; i++) eval_tbl[i] = 3'($urandom);
    rst = 1'b1; start = 1'b0; seat_req = '0; seat_cards = '0; call_thr = '0; raise_thr = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {busy, done, eval_req, eval_card1, eval_card2, strength_all, action_all, card_err}, '0);
    rst = 1'b0;

    // Pocket aces alone
    c_a = mk(2'b00, 4'd14); c_b = mk(2'b01, 4'd14);
    eval_tbl[{c_a, c_b}] = 3'd7;
    run_round("aa", 4'b0001, {rand_hand(), rand_hand(), rand_hand(), c_a, c_b}, 3'd4, 3'd6, 1'b0);
    check("aa_const", {strength_all[2:0], action_all}, {3'd7, 8'b11_11_11_10});

    // Four seats: 72o, AKo, QJs, 55
    h0 = {mk(2'd0, 4'd7), mk(2'd1, 4'd2)};
    h1 = {mk(2'd2, 4'd14), mk(2'd3, 4'd13)};
    h2 = {mk(2'd1, 4'd12), mk(2'd1, 4'd11)};
    h3 = {mk(2'd0, 4'd5), mk(2'd3, 4'd5)};
    eval_tbl[h0] = 3'd0; eval_tbl[h1] = 3'd6; eval_tbl[h2] = 3'd5; eval_tbl[h3] = 3'd3;
    round4 = {h3, h2, h1, h0};
    run_round("four", 4'b1111, round4, 3'd4, 3'd6, 1'b0);
    check("four_const", action_all, 8'b00_01_10_00);

    // Invalid rank on seat 1, duplicated card on seat 2
    h1 = {mk(2'd2, 4'd9), mk(2'd0, 4'd15)};
    h2 = {mk(2'd3, 4'd8), mk(2'd3, 4'd8)};
    eval_tbl[h1] = 3'd7; eval_tbl[h2] = 3'd7;
    run_round("bad", 4'b1111, {h3, h2, h1, h0}, 3'd4, 3'd6, 1'b0);
    check("bad_const", {card_err, strength_all[8:3], action_all[5:2]}, {4'b0110, 6'd0, 4'b0000});

    // Start with no seats is ignored
    @(negedge clk);
    start = 1'b1; seat_req = 4'd0; seat_cards = {16'($urandom), 32'($urandom)};
    @(posedge clk); #1;
    start = 1'b0;
    cnt = 0;
    repeat (6) begin
      if (busy || done) cnt++;
      @(posedge clk); #1;
    end
    check("empty_start_idle", cnt, 0);
    check("empty_start_hold", {strength_all, action_all, card_err}, {exp_s, exp_a, exp_e});

    // Start pulsed while busy must not restart or disturb the round
    run_round("poke", 4'b1111, round4, 3'd4, 3'd6, 1'b1);
    check("poke_const", action_all, 8'b00_01_10_00);

    // Thresholds at the extremes
    h0 = {mk(2'd0, 4'd3), mk(2'd2, 4'd4)};
    h1 = {mk(2'd1, 4'd10), mk(2'd3, 4'd10)};
    eval_tbl[h0] = 3'd0; eval_tbl[h1] = 3'd7;
    run_round("thr", 4'b0011, {rand_hand(), rand_hand(), h1, h0}, 3'd0, 3'd7, 1'b0);
    check("thr_const", action_all, 8'b11_11_10_01);

    // Reset during the evaluation of seat 2
    @(negedge clk);
    start = 1'b1; seat_req = 4'hF; seat_cards = round4; call_thr = 3'd4; raise_thr = 3'd6;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) begin @(posedge clk); #1; end
    check("abort_in_eval", eval_req, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_outputs", {busy, done, eval_req, eval_card1, eval_card2, strength_all, action_all, card_err}, '0);
    rst = 1'b0;
    cnt = 0;
    repeat (15) begin
      if (done || busy) cnt++;
      @(posedge clk); #1;
    end
    check("abort_no_done", cnt, 0);
    run_round("after_abort", 4'b1111, round4, 3'd4, 3'd6, 1'b0);

    // Randomized rounds
    for (int r = 0; r < 30; r++) begin
      logic [3:0] rq;
      rq = 4'($urandom_range(1, 15));
      run_round("rand", rq, {rand_hand(), rand_hand(), rand_hand(), rand_hand()},
                3'($urandom), 3'($urandom), ($urandom_range(0, 3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
